sdram_aref: RTL and testbench
=============================

Name: sdram_aref

Overview:
Periodic auto-refresh generator for the SDRAM controller. It sits downstream of the power-up init stage and is enabled by that stage's flag_init_end. It times the refresh interval and requests the command bus from the arbiter. Once granted, it drives one PRECHARGE-all followed by two AUTO_REFRESH commands, then signals completion to the arbiter.

Parameters:
REF_PERIOD, 780, refresh interval in sys_clk cycles (15.6 us at 50 MHz); must exceed 2+T_RP+2*T_RC
T_RP, 2, cycles from PRECHARGE to first AUTO_REFRESH
T_RC, 7, cycles between successive AUTO_REFRESH commands, and from the last AUTO_REFRESH to the end pulse

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
sys_rst  in  1  reset, asynchronous, active-high
flag_init_end  in  1  level; init sequence complete
aref_en  in  1  arbiter grant; only meaningful while aref_req=1
aref_req  out  1  refresh request to arbiter
aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n} command
aref_addr  out  12  SDRAM address bus value
flag_aref_end  out  1  one-cycle pulse: refresh sequence finished, bus released
aref_overrun  out  1  sticky: a refresh interval elapsed while the previous request was still ungranted

Behaviour:
- Reset (async, sys_rst=1): FSM=IDLE, cnt_ref=0, pending=0, aref_req=0, aref_cmd=NOP (4'b0111), flag_aref_end=0, aref_overrun=0.
- aref_addr is constant 12'b0100_0000_0000 (A10=1, all-bank precharge).
- All outputs are registered.
- Interval counter cnt_ref (width clog2(REF_PERIOD)):
  - Held at 0 while flag_init_end=0.
  - Otherwise counts 0..REF_PERIOD-1, then wraps to 0.
  - Wrap cycle = tick. It keeps counting during a refresh sequence (issue-to-issue period).
- On a tick: pending<=1. If pending is already 1 and the grant has not been accepted on that same cycle, aref_overrun<=1 (sticky until reset). Requests coalesce; only one sequence runs.
- FSM states: IDLE, REQ, PRE, WAIT_RP, AREF1, WAIT_RC1, AREF2, WAIT_RC2, END.
  - IDLE -> REQ when pending=1. aref_req=1 in REQ.
  - REQ -> PRE on the cycle aref_en is sampled high (call it cycle 0). pending clears on cycle 0; a tick on cycle 0 re-sets pending without overrun.
  - aref_en is ignored in every state except REQ.
- Command timeline relative to cycle 0 (registered outputs):
  - cycle 1: aref_cmd=PRECHARGE (4'b0010), aref_req=0
  - cycle 1+T_RP: AUTO_REFRESH (4'b0001)
  - cycle 1+T_RP+T_RC: AUTO_REFRESH
  - cycle 1+T_RP+2*T_RC: flag_aref_end=1 for exactly one cycle
  - all other cycles: NOP
  - Defaults: PRE@1, AREF@3, AREF@10, END@17.
- After END, FSM returns to IDLE. If pending=1, aref_req reasserts one cycle after IDLE is entered.
- flag_init_end falling mid-sequence: counter clears and holds, pending clears, the in-flight sequence completes normally. flag_init_end is expected to stay high after rising.
- aref_req stays high until granted; there is no timeout.
- Reset asserted mid-sequence: immediate return to reset values, with no further commands.

Decomposition:
- Shared package sdram_pkg holds:
  - command encodings NOP, PRECHARGE, AUTO_REFRESH, MODE_SET, ACTIVE, READ, WRITE
  - ADDR_ALL_BANK = 12'b0100_0000_0000
  - default timing constants (T_RP, T_RC, REF_PERIOD)
  - the FSM state enumeration
- One natural sub-module: sdram_ref_timer. It owns the interval counter, tick generation, pending and overrun logic; the top keeps the FSM and command/flag outputs.

Test Plan:
- Hold flag_init_end=0 for 2000 cycles -> aref_req=0, aref_cmd=NOP throughout, cnt_ref=0.
- REF_PERIOD=40: raise flag_init_end, aref_en tied high -> aref_req rises one cycle after the tick (cycle 40); PRECHARGE one cycle after the grant; AUTO_REFRESH 2 and 9 cycles after that; flag_aref_end one 1-cycle pulse 16 cycles after PRECHARGE; aref_addr=12'h400 throughout.
- REF_PERIOD=40, aref_en held low for 90 cycles -> aref_req stays high, aref_overrun=1 at the second tick. Raise aref_en -> exactly one sequence runs, then aref_req reasserts if a third tick occurred.
- Pulse aref_en while FSM is in IDLE or WAIT_RC1 -> no state change and no extra commands.
- Assert sys_rst asynchronously between the two AUTO_REFRESH commands -> outputs return to reset values before the next clock edge. After release and flag_init_end=1, the first request occurs REF_PERIOD cycles later.
- Drop flag_init_end during WAIT_RP -> the sequence completes (2 AUTO_REFRESH commands, END pulse), then no further aref_req.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, address constants,
// default timing and the auto-refresh FSM state set.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_MODE_SET     = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;

  localparam logic [11:0] ADDR_ALL_BANK = 12'b0100_0000_0000;

  localparam int DEF_T_RP       = 2;
  localparam int DEF_T_RC       = 7;
  localparam int DEF_REF_PERIOD = 780;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    PRE,
    WAIT_RP,
    AREF1,
    WAIT_RC1,
    AREF2,
    WAIT_RC2,
    END
  } aref_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: free-running interval counter, coalesced pending
// request and sticky overrun detection.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic flag_init_end,
  input  logic grant,
  output logic pending,
  output logic overrun
);

  localparam int CNT_W = $clog2(REF_PERIOD);

  logic [CNT_W-1:0] cnt_ref;
  logic             tick;

  assign tick = flag_init_end && (cnt_ref == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_ref <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!flag_init_end || tick) cnt_ref <= '0;
      else                        cnt_ref <= cnt_ref + 1'b1;

      // A tick landing on the grant cycle starts a fresh request, not an overrun.
      if (!flag_init_end) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
        if (pending && !grant) overrun <= 1'b1;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_aref.sv
// Periodic auto-refresh generator: requests the bus, then issues
// PRECHARGE-all followed by two AUTO_REFRESH commands and an end pulse.
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int T_RP       = DEF_T_RP,
  parameter int T_RC       = DEF_T_RC
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        flag_init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [11:0] aref_addr,
  output logic        flag_aref_end,
  output logic        aref_overrun
);

  localparam int WAIT_MAX = (T_RC > T_RP) ? T_RC : T_RP;
  localparam int WCNT_W   = $clog2(WAIT_MAX + 1);

  aref_state_t       state;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              grant;
  logic              pending;

  assign grant     = (state == REQ) && aref_en;
  assign wcnt_inc  = wcnt + 1'b1;
  assign aref_addr = ADDR_ALL_BANK;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_timer (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .flag_init_end (flag_init_end),
    .grant         (grant),
    .pending       (pending),
    .overrun       (aref_overrun)
  );

  // wcnt counts cycles since the last issued command; the next command
  // goes out on the edge where that distance reaches the timing parameter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      wcnt          <= '0;
      aref_req      <= 1'b0;
      aref_cmd      <= CMD_NOP;
      flag_aref_end <= 1'b0;
    end else begin
      aref_cmd      <= CMD_NOP;
      flag_aref_end <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            state    <= REQ;
            aref_req <= 1'b1;
          end
        end
        REQ: begin
          if (aref_en) begin
            state    <= PRE;
            aref_req <= 1'b0;
            aref_cmd <= CMD_PRECHARGE;
            wcnt     <= '0;
          end
        end
        PRE, WAIT_RP: begin
          if (wcnt_inc == WCNT_W'(T_RP)) begin
            state    <= AREF1;
            aref_cmd <= CMD_AUTO_REFRESH;
            wcnt     <= '0;
          end else begin
            state <= WAIT_RP;
            wcnt  <= wcnt_inc;
          end
        end
        AREF1, WAIT_RC1: begin
          if (wcnt_inc == WCNT_W'(T_RC)) begin
            state    <= AREF2;
            aref_cmd <= CMD_AUTO_REFRESH;
            wcnt     <= '0;
          end else begin
            state <= WAIT_RC1;
            wcnt  <= wcnt_inc;
          end
        end
        AREF2, WAIT_RC2: begin
          if (wcnt_inc == WCNT_W'(T_RC)) begin
            state         <= END;
            flag_aref_end <= 1'b1;
            wcnt          <= '0;
          end else begin
            state <= WAIT_RC2;
            wcnt  <= wcnt_inc;
          end
        end
        END: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: offset-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed cycle indices.
module tb_sdram_aref;

  localparam int RP  = 40;
  localparam int TRP = 2;
  localparam int TRC = 7;
  localparam int E   = 1 + TRP + 2 * TRC;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        flag_init_end;
  logic        aref_en;
  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;
  logic        flag_aref_end;
  logic        aref_overrun;

  sdram_aref #(
    .REF_PERIOD (RP),
    .T_RP       (TRP),
    .T_RC       (TRC)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .flag_init_end (flag_init_end),
    .aref_en       (aref_en),
    .aref_req      (aref_req),
    .aref_cmd      (aref_cmd),
    .aref_addr     (aref_addr),
    .flag_aref_end (flag_aref_end),
    .aref_overrun  (aref_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: outputs derive from the offset since the grant edge and the
  // number of enabled cycles since flag_init_end rose.
  int         m_cyc     = 0;
  int         m_gcyc    = -1;
  int         m_elapsed = 0;
  int         m_off;
  bit         m_pend    = 1'b0;
  bit         m_ovr     = 1'b0;
  bit         m_req     = 1'b0;
  bit         m_grant, m_tick, m_idle, m_next_req;
  logic [3:0] x_cmd     = 4'b0111;
  bit         x_end     = 1'b0;

  initial begin
    forever begin
      @(posedge sys_clk or posedge sys_rst);
      if (sys_rst) begin
        m_elapsed = 0;
        m_pend    = 1'b0;
        m_ovr     = 1'b0;
        m_req     = 1'b0;
        m_gcyc    = -1;
        x_cmd     = 4'b0111;
        x_end     = 1'b0;
      end else begin
        m_grant    = m_req && aref_en;
        m_tick     = flag_init_end && ((m_elapsed % RP) == RP - 1);
        m_idle     = !m_req && (m_gcyc < 0 || (m_cyc - 1 - m_gcyc) >= E);
        if (m_tick && m_pend && !m_grant) m_ovr = 1'b1;
        m_next_req = m_grant ? 1'b0 : (m_req || (m_idle && m_pend));
        if (m_grant) m_gcyc = m_cyc;
        if (!flag_init_end) m_pend = 1'b0;
        else if (m_tick)    m_pend = 1'b1;
        else if (m_grant)   m_pend = 1'b0;
        m_elapsed = flag_init_end ? m_elapsed + 1 : 0;
        m_req     = m_next_req;
        m_off     = (m_gcyc < 0) ? 0 : (m_cyc - m_gcyc + 1);
        if (m_off == 1)                                  x_cmd = 4'b0010;
        else if (m_off == 1 + TRP || m_off == 1 + TRP + TRC) x_cmd = 4'b0001;
        else                                             x_cmd = 4'b0111;
        x_end = (m_off == E);
      end
      m_cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      chk("req",     {31'd0, aref_req},      {31'd0, m_req});
      chk("cmd",     {28'd0, aref_cmd},      {28'd0, x_cmd});
      chk("addr",    {20'd0, aref_addr},     32'h400);
      chk("end",     {31'd0, flag_aref_end}, {31'd0, x_end});
      chk("overrun", {31'd0, aref_overrun},  {31'd0, m_ovr});
    end
  end

  // Directed observation of event cycle indices.
  int first_req, pre_idx, aref_a, aref_b, end_idx;
  int n_pre, n_aref, n_end, req_late;

  task automatic obs_clear();
    first_req = -1; pre_idx = -1; aref_a = -1; aref_b = -1; end_idx = -1;
    n_pre = 0; n_aref = 0; n_end = 0; req_late = 0;
  endtask

  task automatic obs_cycle(input int i);
    if (aref_req && first_req < 0) first_req = i;
    if (aref_req && i > E + 41) req_late++;
    if (aref_cmd == 4'b0010) begin
      if (n_pre == 0) pre_idx = i;
      n_pre++;
    end
    if (aref_cmd == 4'b0001) begin
      if (n_aref == 0) aref_a = i;
      else if (n_aref == 1) aref_b = i;
      n_aref++;
    end
    if (flag_aref_end) begin
      if (n_end == 0) end_idx = i;
      n_end++;
    end
  endtask

  task automatic do_reset();
    sys_rst       = 1'b1;
    flag_init_end = 1'b0;
    aref_en       = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  int   nz_req, nz_cmd, nz_cnt;
  logic ovr78, ovr79, req89, req119, req120;
  logic [3:0] cmd_before_rst;

  initial begin
    sys_rst       = 1'b1;
    flag_init_end = 1'b0;
    aref_en       = 1'b0;
    #1;
    chk("rst_req",     {31'd0, aref_req},      32'd0);
    chk("rst_cmd",     {28'd0, aref_cmd},      32'h7);
    chk("rst_end",     {31'd0, flag_aref_end}, 32'd0);
    chk("rst_overrun", {31'd0, aref_overrun},  32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    // flag_init_end held low
    nz_req = 0; nz_cmd = 0; nz_cnt = 0;
    repeat (2000) begin
      @(posedge sys_clk);
      #1;
      if (aref_req) nz_req++;
      if (aref_cmd !== 4'b0111) nz_cmd++;
      if (dut.u_timer.cnt_ref != 0) nz_cnt++;
    end
    chk("noinit_req_cycles", nz_req, 0);
    chk("noinit_cmd_cycles", nz_cmd, 0);
    chk("noinit_cnt_cycles", nz_cnt, 0);

    // Basic sequence with grant tied high
    do_reset();
    flag_init_end = 1'b1;
    aref_en       = 1'b1;
    obs_clear();
    for (int i = 0; i < 60; i++) begin
      @(posedge sys_clk);
      #1;
      obs_cycle(i);
    end
    chk("basic_first_req", first_req, 40);
    chk("basic_pre",       pre_idx,   41);
    chk("basic_aref1",     aref_a,    43);
    chk("basic_aref2",     aref_b,    50);
    chk("basic_end",       end_idx,   57);
    chk("basic_end_count", n_end,     1);

    // Grant withheld across two ticks
    do_reset();
    flag_init_end = 1'b1;
    obs_clear();
    for (int i = 0; i < 130; i++) begin
      @(posedge sys_clk);
      #1;
      obs_cycle(i);
      if (i == 78) ovr78 = aref_overrun;
      if (i == 79) ovr79 = aref_overrun;
      if (i == 89) begin
        req89   = aref_req;
        aref_en = 1'b1;
      end
      if (i == 90) aref_en = 1'b0;
      if (i == 119) req119 = aref_req;
      if (i == 120) req120 = aref_req;
    end
    chk("ovr_before_tick2", {31'd0, ovr78},  32'd0);
    chk("ovr_at_tick2",     {31'd0, ovr79},  32'd1);
    chk("ovr_req_held",     {31'd0, req89},  32'd1);
    chk("ovr_pre",          pre_idx,         90);
    chk("ovr_pre_count",    n_pre,           1);
    chk("ovr_end",          end_idx,         106);
    chk("ovr_req_pre_tick3", {31'd0, req119}, 32'd0);
    chk("ovr_req_tick3",    {31'd0, req120}, 32'd1);
    chk("ovr_sticky",       {31'd0, aref_overrun}, 32'd1);

    // Stray grant pulses in IDLE and WAIT_RC1
    do_reset();
    flag_init_end = 1'b1;
    obs_clear();
    for (int i = 0; i < 70; i++) begin
      @(posedge sys_clk);
      #1;
      obs_cycle(i);
      if (i == 10) aref_en = 1'b1;
      if (i == 11) aref_en = 1'b0;
      if (i == 40) aref_en = 1'b1;
      if (i == 41) aref_en = 1'b0;
      if (i == 45) aref_en = 1'b1;
      if (i == 46) aref_en = 1'b0;
    end
    chk("stray_first_req",  first_req, 40);
    chk("stray_pre",        pre_idx,   41);
    chk("stray_pre_count",  n_pre,     1);
    chk("stray_aref_count", n_aref,    2);
    chk("stray_aref2",      aref_b,    50);
    chk("stray_end",        end_idx,   57);
    chk("stray_end_count",  n_end,     1);

    // Asynchronous reset right after the first AUTO_REFRESH is issued
    do_reset();
    flag_init_end = 1'b1;
    aref_en       = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(posedge sys_clk);
      #1;
    end
    cmd_before_rst = aref_cmd;
    chk("arst_cmd_before", {28'd0, cmd_before_rst}, 32'h1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_cmd", {28'd0, aref_cmd},      32'h7);
    chk("arst_req", {31'd0, aref_req},      32'd0);
    chk("arst_end", {31'd0, flag_aref_end}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    obs_clear();
    for (int i = 0; i < 45; i++) begin
      @(posedge sys_clk);
      #1;
      obs_cycle(i);
    end
    chk("arst_first_req", first_req, 40);
    chk("arst_pre",       pre_idx,   41);

    // flag_init_end dropped during WAIT_RP
    do_reset();
    flag_init_end = 1'b1;
    aref_en       = 1'b1;
    obs_clear();
    for (int i = 0; i < 260; i++) begin
      @(posedge sys_clk);
      #1;
      obs_cycle(i);
      if (i == 42) flag_init_end = 1'b0;
    end
    chk("drop_pre_count",  n_pre,    1);
    chk("drop_aref_count", n_aref,   2);
    chk("drop_aref2",      aref_b,   50);
    chk("drop_end",        end_idx,  57);
    chk("drop_end_count",  n_end,    1);
    chk("drop_req_late",   req_late, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
